// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

    // Operation select driven by the controller's funct decode
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_ZDIV = 2'b11
    } state_e;

    // Divide ops have op[1] set
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    // Signed ops have op[0] clear
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Per-cycle datapath: shift-add multiply or restoring divide, one bit per step.
// Ports: clock/reset; load captures a_in (multiplier/dividend) and b_in
// (multiplicand/divisor); step advances one iteration in the mode given by
// div_mode; acc holds product high half / remainder, sr holds product low
// half / quotient.
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sr
);

    localparam int unsigned XW = WIDTH + 1;

    logic [WIDTH-1:0] dreg;
    logic [XW-1:0]    mul_sum;
    logic [XW-1:0]    div_sh;
    logic [XW-1:0]    div_diff;
    logic             div_ge;

    // Next-iteration arithmetic for both modes
    always_comb begin
        mul_sum  = {1'b0, acc} + (sr[0] ? {1'b0, dreg} : XW'(0));
        div_sh   = {acc, sr[WIDTH-1]};
        div_diff = div_sh - {1'b0, dreg};
        div_ge   = (div_sh >= {1'b0, dreg});
    end

    // Multiply shifts {acc,sr} right; divide shifts it left and subtracts
    // when the partial remainder covers the divisor (acc < dreg always holds).
    always_ff @(posedge clock) begin
        if (reset) begin
            acc  <= '0;
            sr   <= '0;
            dreg <= '0;
        end else if (load) begin
            acc  <= '0;
            sr   <= a_in;
            dreg <= b_in;
        end else if (step) begin
            if (div_mode) begin
                acc <= div_ge ? WIDTH'(div_diff) : WIDTH'(div_sh);
                sr  <= {sr[WIDTH-2:0], div_ge};
            end else begin
                acc <= WIDTH'(mul_sum >> 1);
                sr  <= {mul_sum[0], sr[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Ports: clock, reset (sync, active-high); start/op/src_a/src_b issue an op;
// mthi/mtlo/wdata write HI/LO while idle; hilo_read flags MFHI/MFLO;
// hi/lo are the architectural registers; busy marks an op in flight;
// done pulses the cycle after HI/LO take a result; stall holds the pipeline.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned PW = 2 * WIDTH;

    state_e           state, state_nx;
    op_e              op_in, op_q;
    logic [CNT_W-1:0] cnt;
    logic             sign_a, sign_b;
    logic             accept, step, zdiv_in, sgn_in;
    logic [WIDTH-1:0] a_ld, b_ld;
    logic [WIDTH-1:0] core_acc, core_sr;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign op_in   = op_e'(op);
    assign sgn_in  = op_is_signed(op_in);
    assign zdiv_in = op_is_div(op_in) && (src_b == '0);

    // Requests that cannot be served while an op is in flight
    assign stall = busy & (hilo_read | start | mthi | mtlo);

    // Signed ops load magnitudes; divide-by-zero keeps raw src_a for HI
    always_comb begin
        a_ld = (sgn_in && src_a[WIDTH-1] && !zdiv_in) ? -src_a : src_a;
        b_ld = (sgn_in && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state and control strobes
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = zdiv_in ? S_ZDIV : S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_nx = S_FIX;
            end
            S_FIX:   state_nx = S_IDLE;
            S_ZDIV:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Sign fixup of the unsigned loop result
    always_comb begin
        prod = {core_acc, core_sr};
        if (op_is_div(op_q)) begin
            res_lo = (sign_a ^ sign_b) ? -core_sr : core_sr;
            res_hi = sign_a ? -core_acc : core_acc;
        end else begin
            if (sign_a ^ sign_b) prod = -prod;
            res_hi = prod[PW-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // Counter, op latch, HI/LO and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= OP_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state == S_FIX) || (state == S_ZDIV);
            if (accept) begin
                cnt    <= '0;
                op_q   <= op_in;
                sign_a <= sgn_in & src_a[WIDTH-1];
                sign_b <= sgn_in & src_b[WIDTH-1];
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == S_ZDIV) begin
                hi <= core_sr;
                lo <= '1;
            end else if (state == S_IDLE) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end
        end
    end

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .step     (step),
        .div_mode (op_is_div(op_q)),
        .a_in     (a_ld),
        .b_in     (b_ld),
        .acc      (core_acc),
        .sr       (core_sr)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors, random ops against
// an arithmetic reference model, and multi-cycle stall/reset sequences.
module tb_muldiv_ctrl;

    localparam int unsigned W = 32;

    logic         clock;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b, wdata;
    logic         mthi, mtlo, hilo_read;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hilo_read (hilo_read),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           exp_lat;
    } vec_t;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (o[1] && b == 0) begin
            h = a;
            l = '1;
        end else begin
            case (o)
                2'b00: p = 64'(sa * sb);
                2'b01: p = 64'(ua * ub);
                2'b10: begin q = sa / sb; r = sa % sb; p = {32'(r), 32'(q)}; end
                default: begin uq = ua / ub; ur = ua % ub; p = {32'(ur), 32'(uq)}; end
            endcase
            h = p[63:32];
            l = p[31:0];
        end
    endfunction

    // Issue one op while idle; report result, latency and busy cycles
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] h, output logic [W-1:0] l,
                          output int lat, output int bcnt);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clock); #1;
        start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busy) bcnt++;
            @(posedge clock); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        h = hi;
        l = lo;
    endtask

    vec_t vecs[10];
    logic [W-1:0] rh, rl, eh, el;
    int lat, bcnt, dcount;

    initial begin
        vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 33};
        vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
        vecs[7] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
        vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
        vecs[9] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33};

        reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; hilo_read = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        // Idle MTHI / MTLO
        mthi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clock); #1; mthi = 1'b0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'h0);
        mtlo = 1'b1; wdata = 32'h0000_5678;
        @(posedge clock); #1; mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h0000_5678);
        check("mtlo_hi", hi, 32'h0000_1234);

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, lat, bcnt);
            check($sformatf("vec%0d_hi", i), rh, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), rl, vecs[i].exp_lo);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].exp_lat));
            @(posedge clock); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
        end

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [W-1:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : W'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = '1;
                default: b = W'($urandom);
            endcase
            ref_op(o, a, b, eh, el);
            run_op(o, a, b, rh, rl, lat, bcnt);
            check($sformatf("rnd%0d_hi op%0d a=%08h b=%08h", i, o, a, b), rh, eh);
            check($sformatf("rnd%0d_lo op%0d a=%08h b=%08h", i, o, a, b), rl, el);
            check($sformatf("rnd%0d_lat", i), 32'(lat), (o[1] && b == 0) ? 32'd1 : 32'd33);
        end

        // Stall sequence: MFHI held from cycle 5, ignored start/mthi mid-op
        start = 1'b1; op = 2'b00; src_a = 32'h7; src_b = 32'hFFFF_FFFD;
        @(posedge clock); #1; start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clock); #1;
            hilo_read = (cyc >= 5 && cyc <= 36);
            start = (cyc == 10);
            op = 2'b11; src_a = 32'h1; src_b = 32'h1;
            mthi = (cyc == 12); wdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("stall_c%0d", cyc), 32'(stall), 32'(cyc >= 5 && cyc <= 32));
            check($sformatf("done_c%0d", cyc), 32'(done), 32'(cyc == 33));
            check($sformatf("busy_c%0d", cyc), 32'(busy), 32'(cyc <= 32));
        end
        hilo_read = 1'b0; start = 1'b0; mthi = 1'b0;
        check("stall_seq_hi", hi, 32'hFFFF_FFFF);
        check("stall_seq_lo", lo, 32'hFFFF_FFEB);

        // Idle write accepted together with start; op result wins at the end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clock); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("wr_start_hi", hi, 32'hA5A5_A5A5);
        check("wr_start_lo", lo, 32'hA5A5_A5A5);
        check("wr_start_busy", 32'(busy), 1);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock); #1;
            if (done) begin lat = k; break; end
        end
        check("wr_start_lat", 32'(lat), 32'd33);
        check("wr_start_res_hi", hi, 32'd2);
        check("wr_start_res_lo", lo, 32'd14);

        // Reset in the middle of a DIV aborts it
        start = 1'b1; op = 2'b10; src_a = 32'hFFFF_FFF9; src_b = 32'h2;
        @(posedge clock); #1; start = 1'b0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 10) reset = 1'b1;
            if (cyc == 11) begin
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                check("abort_hi", hi, '0);
                check("abort_lo", lo, '0);
                reset = 1'b0;
            end
        end
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done || busy) dcount++;
        end
        check("abort_no_done", 32'(dcount), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
